// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the physical-memory arbiter (state encoding and request latch)
package rv32i_types;

  localparam int PMEM_ADDR_W = 32;
  localparam int PMEM_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } pmem_arb_state_t;

  // Latched downstream request; widths are the largest supported line/address
  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [PMEM_ADDR_W-1:0] address;
    logic [PMEM_LINE_W-1:0] wdata;
  } pmem_req_t;

endpackage

// File: rtl/pmem_arb_pick.sv
// pmem_arb_pick: one-hot tie-break between I and D; round-robin when PMEM_ARB_ROUND_ROBIN_EN is defined, else D wins
module pmem_arb_pick (
  input  logic       req_i_i,
  input  logic       req_d_i,
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  input  logic       last_d_i,
`endif
  output logic [1:0] gnt_o
);

  logic tie_to_i;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  assign tie_to_i = last_d_i;
`else
  assign tie_to_i = 1'b0;
`endif

  assign gnt_o[0] = req_i_i & (~req_d_i | tie_to_i);
  assign gnt_o[1] = req_d_i & (~req_i_i | ~tie_to_i);

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one cacheline-adaptor port between I and D caches, one transaction at a time (macro PMEM_ARB_ROUND_ROBIN_EN selects round-robin ties)
module pmem_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pmem_arb_state_t state_q;
  pmem_req_t       req_q;
  pmem_req_t       cand_i;
  pmem_req_t       cand_d;
  logic [1:0]      gnt;
  logic            pend_i;
  logic            pend_d;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic            last_d_q;
`endif

  assign pend_i = i_pmem_read;
  assign pend_d = d_pmem_read | d_pmem_write;

  pmem_arb_pick u_pick (
    .req_i_i  (pend_i),
    .req_d_i  (pend_d),
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    .last_d_i (last_d_q),
`endif
    .gnt_o    (gnt)
  );

  // Candidate latch contents per requester; a D write suppresses a simultaneous D read
  always_comb begin
    cand_i         = '0;
    cand_i.read    = 1'b1;
    cand_i.address = PMEM_ADDR_W'(i_pmem_address);
    cand_d         = '0;
    cand_d.read    = d_pmem_read & ~d_pmem_write;
    cand_d.write   = d_pmem_write;
    cand_d.address = PMEM_ADDR_W'(d_pmem_address);
    cand_d.wdata   = PMEM_LINE_W'(d_pmem_wdata);
  end

  // Grant FSM: latch the winner in IDLE, hold until the adaptor responds, then release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b1;
`endif
    end else if (state_q == IDLE) begin
      if (gnt[0]) begin
        state_q  <= SERVE_I;
        req_q    <= cand_i;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        last_d_q <= 1'b0;
`endif
      end else if (gnt[1]) begin
        state_q  <= SERVE_D;
        req_q    <= cand_d;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        last_d_q <= 1'b1;
`endif
      end
    end else if (pmem_resp) begin
      state_q <= IDLE;
      req_q   <= '0;
    end
  end

  // Simulation-only flag for the D-side read+write protocol error
  always_ff @(posedge clk) begin
    if (rst) assert (!(d_pmem_read && d_pmem_write));
  end

  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_address = ADDR_W'(req_q.address);
  assign pmem_wdata   = LINE_W'(req_q.wdata);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed plus randomized transactions checked against a transaction-level arbitration model
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_pmem_read = 1'b0;
  logic [31:0]  i_pmem_address = '0;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [31:0]  d_pmem_address = '0;
  logic [255:0] d_pmem_wdata = '0;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks = 0;
  int errors = 0;
  bit last_d = 1'b1;

  pmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit tie_goes_to_i();
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    return last_d;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full transaction: present requests, predict the winner, follow it to the response
  task automatic txn(input bit ir, input bit dr, input bit dw, input logic [31:0] ia,
                     input logic [31:0] da, input logic [255:0] wd, input int lat, input bit chg);
    bit           win_d;
    logic         er, ew;
    logic [31:0]  ea;
    logic [255:0] ewd, rd;
    @(negedge clk);
    i_pmem_read = ir; d_pmem_read = dr; d_pmem_write = dw;
    i_pmem_address = ia; d_pmem_address = da; d_pmem_wdata = wd;
    #1;
    chk1("pre_grant_read", pmem_read, 1'b0);
    chk1("pre_grant_write", pmem_write, 1'b0);
    win_d  = (ir && (dr || dw)) ? !tie_goes_to_i() : !ir;
    last_d = win_d;
    er  = win_d ? (dr && !dw) : 1'b1;
    ew  = win_d ? dw : 1'b0;
    ea  = win_d ? da : ia;
    ewd = win_d ? wd : '0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      rd = rnd_line();
      if (k == lat) begin
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
      end
      #1;
      chk1("svc_read", pmem_read, er);
      chk1("svc_write", pmem_write, ew);
      chkv("svc_addr", 256'(pmem_address), 256'(ea));
      chkv("svc_wdata", pmem_wdata, ewd);
      chk1("i_resp", i_pmem_resp, (k == lat) && !win_d);
      chk1("d_resp", d_pmem_resp, (k == lat) && win_d);
      if (k == lat) chkv("rdata", win_d ? d_pmem_rdata : i_pmem_rdata, rd);
      if (chg && k == 1) d_pmem_address = 32'h0000_2000;
      else if (!chg) begin
        i_pmem_address = $urandom;
        d_pmem_address = $urandom;
        d_pmem_wdata   = rnd_line();
      end
    end
    @(negedge clk);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    chk1("post_read", pmem_read, 1'b0);
    chk1("post_write", pmem_write, 1'b0);
  endtask

  initial begin
    #3;
    chk1("rst_read", pmem_read, 1'b0);
    chk1("rst_write", pmem_write, 1'b0);
    chk1("rst_i_resp", i_pmem_resp, 1'b0);
    chk1("rst_d_resp", d_pmem_resp, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    // Lone I read, lone D writeback
    txn(1, 0, 0, 32'h0000_0060, 32'h0, '0, 5, 0);
    txn(0, 0, 1, 32'h0, 32'h1000_0020, {8{32'hDEADBEEF}}, 4, 0);
    // Three tied rounds
    for (int r = 0; r < 3; r++) txn(1, 1, 0, 32'h0000_0100 + 32'(r), 32'h0000_0200 + 32'(r), '0, 3, 0);
    // Address changes mid-service
    txn(0, 1, 0, 32'h0, 32'h0000_1000, '0, 4, 1);
    // Reset two cycles into a D read
    @(negedge clk);
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    @(negedge clk);
    #1 chk1("rstmid_pre_read", pmem_read, 1'b1);
    @(negedge clk);
    pmem_rdata = rnd_line();
    pmem_resp  = 1'b1;
    rst        = 1'b0;
    #1;
    chk1("rstmid_read", pmem_read, 1'b0);
    chk1("rstmid_write", pmem_write, 1'b0);
    chk1("rstmid_i_resp", i_pmem_resp, 1'b0);
    chk1("rstmid_d_resp", d_pmem_resp, 1'b0);
    chkv("rstmid_addr", 256'(pmem_address), '0);
    chkv("rstmid_rdata", i_pmem_rdata, pmem_rdata);
    last_d = 1'b1;
    @(negedge clk);
    rst = 1'b1; d_pmem_read = 1'b0; pmem_resp = 1'b0;
    txn(1, 0, 0, 32'h0000_0440, 32'h0, '0, 3, 0);
    // Stray adaptor response while idle
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk1("stray_i_resp", i_pmem_resp, 1'b0);
    chk1("stray_d_resp", d_pmem_resp, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk1("stray_read", pmem_read, 1'b0);
    chk1("stray_write", pmem_write, 1'b0);
    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      bit ir;
      int ds;
      ir = 1'($urandom_range(0, 1));
      ds = int'($urandom_range(0, 2));
      if (!ir && ds == 0) ir = 1'b1;
      txn(ir, ds == 1, ds == 2, $urandom, $urandom, rnd_line(), int'($urandom_range(1, 6)), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
